// File: rtl/scmp_bus_if.sv
// SC/MP bus demultiplexer: ADS_n/RD_n/WR_n core strobes to a 16-bit req/ack memory port, stalling the core while busy.
// Optional wait states after ack are built only with SCMP_BUSIF_WAIT_EN defined.
module scmp_bus_if #(
  parameter int         TIMEOUT   = 255,
  parameter logic [7:0] IDLE_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_d_o,
  input  logic        cpu_ads_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  output logic [7:0]  cpu_d_i,
  output logic        cpu_clk_en,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  input  logic [3:0]  wait_cnt,
  output logic        cyc_fetch,
  output logic        halt_p,
  output logic        bus_err
);

  typedef enum logic [2:0] {IDLE, ARMED, ACCESS, WAIT, RELEASE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] to_cnt;
  logic       strobe, ads, start, to_hit;

  assign strobe = !cpu_rd_n || !cpu_wr_n;
  // ADS is only honoured while the core is actually running
  assign ads    = !cpu_ads_n && cpu_clk_en;
  assign start  = (state == ARMED) && strobe;
  assign to_hit = (to_cnt == TO_LAST);

`ifdef SCMP_BUSIF_WAIT_EN
  logic [3:0] wcnt;
  logic       wait_go;
  assign wait_go = (wait_cnt != 4'd0);
`else
  logic unused_wait;
  assign unused_wait = ^wait_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cpu_clk_en = 1'b1;
    case (state)
      IDLE: begin
        if (!cpu_ads_n) state_nxt = ARMED;
      end
      ARMED: begin
        if (strobe) begin
          cpu_clk_en = 1'b0;
          state_nxt  = ACCESS;
        end
      end
      ACCESS: begin
        cpu_clk_en = 1'b0;
        if (mem_ack) begin
`ifdef SCMP_BUSIF_WAIT_EN
          state_nxt = wait_go ? WAIT : RELEASE;
`else
          state_nxt = RELEASE;
`endif
        end else if (to_hit) begin
          state_nxt = RELEASE;
        end
      end
`ifdef SCMP_BUSIF_WAIT_EN
      WAIT: begin
        cpu_clk_en = 1'b0;
        if (wcnt <= 4'd1) state_nxt = RELEASE;
      end
`endif
      RELEASE: begin
        state_nxt = cpu_ads_n ? IDLE : ARMED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_d_i   <= 8'h00;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      mem_we    <= 1'b0;
      mem_req   <= 1'b0;
      cyc_fetch <= 1'b0;
      halt_p    <= 1'b0;
      bus_err   <= 1'b0;
      to_cnt    <= 8'h00;
    end else begin
      halt_p <= 1'b0;
      if (ads) begin
        mem_addr  <= {cpu_d_o[3:0], cpu_addr};
        cyc_fetch <= cpu_d_o[5];
        halt_p    <= cpu_d_o[7];
      end
      if (start) begin
        mem_req         <= 1'b1;
        mem_we          <= !cpu_wr_n;
        mem_wdata       <= cpu_d_o;
        mem_addr[11:0]  <= cpu_addr;
        to_cnt          <= 8'h00;
      end
      if (state == ACCESS) begin
        // an ack on the final timeout cycle still counts as a good completion
        if (mem_ack) begin
          mem_req <= 1'b0;
          if (!mem_we) cpu_d_i <= mem_rdata;
        end else if (to_hit) begin
          mem_req <= 1'b0;
          bus_err <= 1'b1;
          if (!mem_we) cpu_d_i <= IDLE_DATA;
        end else begin
          to_cnt <= to_cnt + 8'd1;
        end
      end
    end
  end

`ifdef SCMP_BUSIF_WAIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           wcnt <= 4'd0;
    else if (state == ACCESS && mem_ack)  wcnt <= wait_cnt;
    else if (state == WAIT)               wcnt <= wcnt - 4'd1;
  end
`endif

endmodule

// File: tb/tb_scmp_bus_if.sv
// Bench for scmp_bus_if: scripted core/memory transactions with per-cycle expectations derived from
// transaction arithmetic (stall = strobe + request cycles + waits), plus literal spot checks.
module tb_scmp_bus_if;

  localparam int TMO = 4;
`ifdef SCMP_BUSIF_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_d_o;
  logic        cpu_ads_n, cpu_rd_n, cpu_wr_n;
  logic [7:0]  cpu_d_i;
  logic        cpu_clk_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_req;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [3:0]  wait_cnt;
  logic        cyc_fetch, halt_p, bus_err;

  scmp_bus_if #(.TIMEOUT(TMO), .IDLE_DATA(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_d_o(cpu_d_o),
    .cpu_ads_n(cpu_ads_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_d_i(cpu_d_i), .cpu_clk_en(cpu_clk_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wait_cnt(wait_cnt),
    .cyc_fetch(cyc_fetch), .halt_p(halt_p), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // expected outputs for the current cycle
  bit          chk_en = 1'b0;
  logic        exp_clk_en = 1'b1, exp_req = 1'b0, exp_we = 1'b0;
  logic        exp_err = 1'b0, exp_halt = 1'b0, exp_fetch = 1'b0;
  logic [7:0]  exp_d_i = 8'h00, exp_wd = 8'h00;
  logic [15:0] exp_addr = 16'h0000;

  // observations gathered per transaction
  int          obs_stall, obs_req, obs_rise, obs_halt;
  logic        prev_req = 1'b0;
  logic [15:0] req_addr;
  logic        req_we;
  logic [7:0]  req_wd, rel_d_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cpu_clk_en", 32'(cpu_clk_en), 32'(exp_clk_en));
      chk("mem_req",    32'(mem_req),    32'(exp_req));
      chk("cpu_d_i",    32'(cpu_d_i),    32'(exp_d_i));
      chk("bus_err",    32'(bus_err),    32'(exp_err));
      chk("halt_p",     32'(halt_p),     32'(exp_halt));
      chk("cyc_fetch",  32'(cyc_fetch),  32'(exp_fetch));
      chk("mem_addr",   32'(mem_addr),   32'(exp_addr));
      if (exp_req) begin
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wd));
      end
      if (!cpu_clk_en) obs_stall++;
      if (halt_p) obs_halt++;
      if (mem_req) begin
        obs_req++;
        if (!prev_req) obs_rise++;
        req_addr = mem_addr; req_we = mem_we; req_wd = mem_wdata;
      end
      prev_req = mem_req;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cpu_ads_n = 1'b1;
      cpu_rd_n  = 1'($urandom_range(0, 1));
      cpu_wr_n  = 1'($urandom_range(0, 1));
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
      cpu_d_o   = 8'($urandom);
      exp_halt  = 1'b0;
      exp_req   = 1'b0;
      exp_clk_en = 1'b1;
    end
  endtask

  // One complete core access; d = memory ack delay after mem_req rises (>= TMO means never)
  task automatic xact(input logic [7:0] hdr, input logic [11:0] addr, input bit do_rd, input bit do_wr,
                      input logic [7:0] wd, input int d, input logic [7:0] rdat, input logic [3:0] wc,
                      input int gap);
    bit tmo;
    int req_len, w;
    tmo     = (d >= TMO);
    req_len = tmo ? TMO : d + 1;
    w       = (!tmo && WAIT_EN) ? int'(wc) : 0;
    obs_stall = 0; obs_req = 0; obs_rise = 0; obs_halt = 0;

    @(posedge clk); #1;
    cpu_ads_n = 1'b0; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; mem_ack = 1'b0;
    cpu_d_o = hdr; cpu_addr = addr; wait_cnt = wc;
    exp_halt = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      cpu_ads_n = 1'b1; cpu_d_o = 8'($urandom);
      exp_halt = (i == 0) ? hdr[7] : 1'b0;
      exp_fetch = hdr[5]; exp_addr = {hdr[3:0], addr};
    end
    @(posedge clk); #1;
    cpu_ads_n = 1'b1; cpu_rd_n = !do_rd; cpu_wr_n = !do_wr; cpu_d_o = wd;
    exp_halt = (gap == 0) ? hdr[7] : 1'b0;
    exp_fetch = hdr[5]; exp_addr = {hdr[3:0], addr};
    exp_clk_en = 1'b0;
    for (int i = 0; i < req_len; i++) begin
      @(posedge clk); #1;
      exp_halt = 1'b0; exp_req = 1'b1; exp_we = do_wr; exp_wd = wd;
      cpu_d_o   = 8'($urandom);
      mem_ack   = !tmo && (i == d);
      mem_rdata = (i == d) ? rdat : 8'($urandom);
    end
    for (int i = 0; i <= w; i++) begin
      @(posedge clk); #1;
      mem_ack = 1'b0; exp_req = 1'b0;
      if (i == 0) begin
        if (!do_wr) exp_d_i = tmo ? 8'hFF : rdat;
        if (tmo) exp_err = 1'b1;
      end
      exp_clk_en = (i == w);
    end
    @(negedge clk);
    rel_d_i = cpu_d_i;
    @(posedge clk); #1;
    cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cpu_addr = 12'h000; cpu_d_o = 8'h00; cpu_ads_n = 1'b1;
    cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; mem_rdata = 8'h00; mem_ack = 1'b0; wait_cnt = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst cpu_clk_en", 32'(cpu_clk_en), 32'd1);
    chk("rst mem_req",    32'(mem_req),    32'd0);
    chk("rst cpu_d_i",    32'(cpu_d_i),    32'd0);
    chk("rst mem_addr",   32'(mem_addr),   32'd0);
    chk("rst bus_err",    32'(bus_err),    32'd0);
    chk("rst halt_p",     32'(halt_p),     32'd0);
    chk("rst cyc_fetch",  32'(cyc_fetch),  32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // strobe with no prior ADS must be ignored
    @(posedge clk); #1; cpu_rd_n = 1'b0;
    @(posedge clk); #1; cpu_rd_n = 1'b1;

    xact(8'h25, 12'h123, 1, 0, 8'h00, 1, 8'hC4, 4'd0, 0);
    chk("read mem_addr", 32'(req_addr), 32'h5123);
    chk("read mem_we",   32'(req_we),   32'd0);
    chk("read stall",    32'(obs_stall), 32'd3);
    chk("read data",     32'(rel_d_i),   32'hC4);
    chk("read fetch",    32'(cyc_fetch), 32'd1);
    idle(2);

    xact(8'h0A, 12'hFFF, 0, 1, 8'h77, 1, 8'h00, 4'd0, 1);
    chk("write mem_addr", 32'(req_addr), 32'hAFFF);
    chk("write mem_we",   32'(req_we),   32'd1);
    chk("write wdata",    32'(req_wd),   32'h77);
    chk("write req count", 32'(obs_rise), 32'd1);
    chk("write bus_err",  32'(bus_err),  32'd0);
    chk("write keeps d_i", 32'(rel_d_i), 32'hC4);
    idle(2);

    xact(8'h80, 12'h010, 1, 0, 8'h00, 0, 8'h3C, 4'd0, 0);
    chk("halt pulses", 32'(obs_halt), 32'd1);
    chk("halt read data", 32'(rel_d_i), 32'h3C);
    idle(2);

    xact(8'h00, 12'h200, 1, 0, 8'h00, 0, 8'h5A, 4'd3, 0);
    chk("wait stall", 32'(obs_stall), WAIT_EN ? 32'd5 : 32'd2);
    idle(2);

    xact(8'h10, 12'h321, 1, 0, 8'h00, 100, 8'h00, 4'd0, 1);
    chk("timeout req cycles", 32'(obs_req), 32'd4);
    chk("timeout bus_err",    32'(bus_err), 32'd1);
    chk("timeout data",       32'(rel_d_i), 32'hFF);
    chk("timeout clk_en",     32'(cpu_clk_en), 32'd1);
    idle(2);

    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      xact(8'($urandom), 12'($urandom), kind != 1, kind != 0, 8'($urandom),
           $urandom_range(0, 6), 8'($urandom), 4'($urandom_range(0, 3)), $urandom_range(0, 2));
      idle($urandom_range(1, 3));
    end

    // reset in the middle of an access
    @(posedge clk); #1; cpu_ads_n = 1'b0; cpu_d_o = 8'h13; cpu_addr = 12'h456; exp_halt = 1'b0;
    @(posedge clk); #1; cpu_ads_n = 1'b1; cpu_rd_n = 1'b0;
    exp_fetch = 1'b0; exp_addr = 16'h3456; exp_clk_en = 1'b0;
    @(posedge clk); #1; exp_req = 1'b1; exp_we = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst mid mem_req",  32'(mem_req),    32'd0);
    chk("rst mid clk_en",   32'(cpu_clk_en), 32'd1);
    chk("rst mid bus_err",  32'(bus_err),    32'd0);
    cpu_rd_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_clk_en = 1'b1; exp_req = 1'b0; exp_we = 1'b0; exp_err = 1'b0; exp_halt = 1'b0;
    exp_fetch = 1'b0; exp_d_i = 8'h00; exp_wd = 8'h00; exp_addr = 16'h0000;
    chk_en = 1'b1;
    idle(1);

    xact(8'h25, 12'h123, 1, 0, 8'h00, 1, 8'h99, 4'd0, 0);
    chk("post-rst mem_addr", 32'(req_addr), 32'h5123);
    chk("post-rst data",     32'(rel_d_i),  32'h99);
    chk("post-rst stall",    32'(obs_stall), 32'd3);
    idle(2);

    for (int n = 0; n < 15; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      xact(8'($urandom), 12'($urandom), kind != 1, kind != 0, 8'($urandom),
           $urandom_range(0, 6), 8'($urandom), 4'($urandom_range(0, 3)), $urandom_range(0, 2));
      idle($urandom_range(1, 3));
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
